// File: rtl/mw_control.sv
// mw_control: memory/writeback-stage control decoder for the RV32I 3-stage pipeline.
// Decodes opcode/funct3 into the data-memory byte-write mask, read enable,
// writeback select and register-file write enable. All decode outputs are
// combinational. The only state is a sticky illegal-opcode flag.
//
// Ports:
//   clk          in   system clock (sticky status register only)
//   rst_n        in   asynchronous active-low reset
//   opcode[6:0]  in   instruction bits [6:0]
//   funct3[2:0]  in   instruction bits [14:12]
//   w_mask[3:0]  out  base byte-write mask, lane 0 = LSB (unshifted)
//   re           out  data-memory read enable
//   wb_sel[1:0]  out  writeback select: 00 ALU, 01 load data, 10 PC+4
//   rwe          out  register-file write enable
//   illegal      out  opcode is not a recognised encoding (combinational)
//   illegal_seen out  sticky registered copy of illegal
module mw_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output logic [3:0] w_mask,
  output logic       re,
  output logic [1:0] wb_sel,
  output logic       rwe,
  output logic       illegal,
  output logic       illegal_seen
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Opcode decode; defaults describe a killed instruction with no side effects.
  always_comb begin
    w_mask  = 4'b0000;
    re      = 1'b0;
    wb_sel  = WB_ALU;
    rwe     = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LUI, OP_AUIPC: begin
        rwe = 1'b1;
      end
      OP_LOAD: begin
        re     = 1'b1;
        wb_sel = WB_MEM;
        rwe    = 1'b1;
      end
      OP_STORE: begin
        // Reserved store widths write nothing.
        case (funct3)
          3'b000:  w_mask = 4'b0001;
          3'b001:  w_mask = 4'b0011;
          3'b010:  w_mask = 4'b1111;
          default: w_mask = 4'b0000;
        endcase
      end
      OP_JAL, OP_JALR: begin
        wb_sel = WB_PC4;
        rwe    = 1'b1;
      end
      // CSR writes use their own path, so SYSTEM leaves the register file alone.
      OP_BRANCH, OP_SYSTEM: begin
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // Sticky illegal-opcode status: set on any illegal cycle, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_seen <= 1'b0;
    end else if (illegal) begin
      illegal_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mw_control.sv
// Self-checking bench for mw_control: directed decode steps with fixed
// expectations, an exhaustive opcode/funct3 sweep against a table model,
// and the sticky illegal flag including asynchronous reset.
module tb_mw_control;

  typedef struct packed {
    logic [3:0] w_mask;
    logic       re;
    logic [1:0] wb_sel;
    logic       rwe;
    logic       illegal;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [3:0] w_mask;
  logic       re;
  logic [1:0] wb_sel;
  logic       rwe;
  logic       illegal;
  logic       illegal_seen;

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        exp_q[$];

  mw_control dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .funct3       (funct3),
    .w_mask       (w_mask),
    .re           (re),
    .wb_sel       (wb_sel),
    .rwe          (rwe),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected decode, written straight from the opcode table.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3);
    exp_t e;
    e = '0;
    if (op == 7'b0000011) begin
      e.re = 1'b1; e.wb_sel = 2'b01; e.rwe = 1'b1;
    end else if (op == 7'b0100011) begin
      if (f3 == 3'd0)      e.w_mask = 4'b0001;
      else if (f3 == 3'd1) e.w_mask = 4'b0011;
      else if (f3 == 3'd2) e.w_mask = 4'b1111;
    end else if (op inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111}) begin
      e.rwe = 1'b1;
    end else if (op inside {7'b1101111, 7'b1100111}) begin
      e.wb_sel = 2'b10; e.rwe = 1'b1;
    end else if (!(op inside {7'b1100011, 7'b1110011})) begin
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one opcode/funct3, queue its expectation, then pop and compare.
  task automatic step(input string tag, input logic [6:0] op, input logic [2:0] f3,
                      input exp_t e);
    exp_t got;
    exp_t want;
    opcode = op;
    funct3 = f3;
    exp_q.push_back(e);
    #1;
    got  = {w_mask, re, wb_sel, rwe, illegal};
    want = exp_q.pop_front();
    chk($sformatf("%s op=%b f3=%b", tag, op, f3), 9'(got), 9'(want));
  endtask

  // Field order: w_mask, re, wb_sel, rwe, illegal.
  localparam exp_t E_ALU  = '{4'b0000, 1'b0, 2'b00, 1'b1, 1'b0};
  localparam exp_t E_LOAD = '{4'b0000, 1'b1, 2'b01, 1'b1, 1'b0};
  localparam exp_t E_JMP  = '{4'b0000, 1'b0, 2'b10, 1'b1, 1'b0};
  localparam exp_t E_NOWR = '{4'b0000, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam exp_t E_ILL  = '{4'b0000, 1'b0, 2'b00, 1'b0, 1'b1};
  localparam exp_t E_SB   = '{4'b0001, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam exp_t E_SH   = '{4'b0011, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam exp_t E_SW   = '{4'b1111, 1'b0, 2'b00, 1'b0, 1'b0};

  initial begin
    rst_n  = 1'b0;
    opcode = 7'b0000000;
    funct3 = 3'b000;

    // Reset held with an illegal opcode across edges keeps the flag clear.
    repeat (2) @(posedge clk);
    #1;
    chk("seen_in_reset", 9'(illegal_seen), 9'd0);

    // Store widths.
    step("sb", 7'b0100011, 3'b000, E_SB);
    step("sh", 7'b0100011, 3'b001, E_SH);
    step("sw", 7'b0100011, 3'b010, E_SW);
    step("s_rsvd", 7'b0100011, 3'b011, E_NOWR);

    // Loads, every funct3.
    for (int f = 0; f < 8; f++) step("load", 7'b0000011, 3'(f), E_LOAD);

    // Jumps and ALU-class.
    step("jal", 7'b1101111, 3'b000, E_JMP);
    step("jalr", 7'b1100111, 3'b000, E_JMP);
    step("jalr_f3", 7'b1100111, 3'b101, E_JMP);
    step("r", 7'b0110011, 3'b111, E_ALU);
    step("i", 7'b0010011, 3'b001, E_ALU);
    step("lui", 7'b0110111, 3'b000, E_ALU);
    step("auipc", 7'b0010111, 3'b110, E_ALU);

    // Branch and system never write.
    for (int f = 0; f < 8; f++) begin
      step("branch", 7'b1100011, 3'(f), E_NOWR);
      step("system", 7'b1110011, 3'(f), E_NOWR);
    end

    // Unlisted opcodes.
    step("bubble", 7'b0000000, 3'b000, E_ILL);
    step("ones", 7'b1111111, 3'b111, E_ILL);
    step("fence", 7'b0001111, 3'b000, E_ILL);

    // Exhaustive sweep against the table model.
    for (int op = 0; op < 128; op++) begin
      for (int f = 0; f < 8; f++) begin
        step("sweep", 7'(op), 3'(f), model(7'(op), 3'(f)));
      end
    end

    // Sticky flag: legal opcode after reset release leaves it clear.
    @(negedge clk);
    opcode = 7'b0110011;
    rst_n  = 1'b1;
    @(posedge clk);
    #1;
    chk("seen_legal", 9'(illegal_seen), 9'd0);

    // Illegal opcode across one edge sets it.
    @(negedge clk);
    opcode = 7'b0000000;
    @(posedge clk);
    #1;
    chk("seen_set", 9'(illegal_seen), 9'd1);

    // Legal opcodes afterwards do not clear it.
    @(negedge clk);
    opcode = 7'b0000011;
    repeat (3) @(posedge clk);
    #1;
    chk("seen_hold", 9'(illegal_seen), 9'd1);

    // Reset mid-cycle clears it without a clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("seen_async_clr", 9'(illegal_seen), 9'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mw_control.md
Name: mw_control

Overview:
- Memory/writeback-stage control decoder for the RV32I 3-stage pipeline.
- Decodes the instruction's opcode and funct3 into four signals:
  - base data-memory byte-write mask
  - data-memory read enable
  - writeback mux select
  - register-file write enable
- Decode outputs are purely combinational; they settle within a fraction of a clock period.
- The only sequential element is a sticky illegal-opcode status flag.

Parameters:
- None.

Ports:
- clk  input  1  system clock; used only by the sticky status register
- rst_n  input  1  asynchronous active-low reset
- opcode  input  7  instruction bits [6:0]
- funct3  input  3  instruction bits [14:12]
- w_mask  output  4  base byte-write mask, byte lane 0 = LSB; address-offset shifting is done elsewhere
- re  output  1  data-memory read enable
- wb_sel  output  2  writeback select: 00 = ALU result, 01 = data-memory load data, 10 = PC+4; 11 is never driven
- rwe  output  1  register-file write enable
- illegal  output  1  combinational flag: opcode is not one of the recognised encodings
- illegal_seen  output  1  sticky registered flag

Behaviour:

Clock and reset:
- One clock, clk.
- Reset is asynchronous and active-low on rst_n.
- rst_n low forces illegal_seen to 0 immediately.
- While rst_n is high, illegal_seen sets to 1 on the rising clk edge when illegal=1.
- Once set, illegal_seen holds until rst_n is asserted.
- Reset has no effect on the combinational outputs.

Combinational outputs:
- w_mask, re, wb_sel, rwe and illegal depend only on opcode and funct3.
- No clock latency.
- They must never be X/Z for any fully-known input, including unused encodings; verification compares wb_sel with case-inequality.

Decode by opcode:
- 0110011 R-type and 0010011 I-type ALU (any funct3): w_mask=0000, re=0, wb_sel=00, rwe=1
- 0110111 LUI, 0010111 AUIPC: w_mask=0000, re=0, wb_sel=00, rwe=1
- 0000011 LOAD (any funct3, including reserved 011/110/111): w_mask=0000, re=1, wb_sel=01, rwe=1
- 0100011 STORE: re=0, wb_sel=00, rwe=0; w_mask by funct3:
  - 000 SB -> 0001
  - 001 SH -> 0011
  - 010 SW -> 1111
  - any other funct3 -> 0000
- 1101111 JAL, 1100111 JALR (any funct3): w_mask=0000, re=0, wb_sel=10, rwe=1
- 1100011 BRANCH (any funct3): w_mask=0000, re=0, wb_sel=00, rwe=0
- 1110011 SYSTEM/CSR (any funct3): w_mask=0000, re=0, wb_sel=00, rwe=0
  - CSR writes go through a separate CSR path, not the register file.
- Any other opcode, including all-zero (pipeline bubble/NOP-kill):
  - w_mask=0000, re=0, wb_sel=00, rwe=0, illegal=1
  - i.e. a killed instruction never writes memory or registers.

Fixed relationships between outputs:
- w_mask is nonzero only for STORE.
- re=1 exactly when opcode=LOAD.
- wb_sel=01 implies re=1.
- illegal=0 for every listed opcode regardless of funct3.

Test Plan:
1. Store widths: opcode=0100011, funct3 000/001/010/011 -> w_mask 0001/0011/1111/0000; re=0, rwe=0, wb_sel=00 in all four cases.
2. Loads: opcode=0000011, every funct3 0..7 -> re=1, wb_sel=01, rwe=1, w_mask=0000.
3. Jumps and ALU:
   - opcode 1101111 and 1100111 -> wb_sel=10, rwe=1.
   - opcodes 0110011, 0010011, 0110111, 0010111 -> wb_sel=00, rwe=1, re=0, w_mask=0000.
4. No-write instructions: opcode 1100011 and 1110011, all funct3 -> rwe=0, re=0, w_mask=0000, wb_sel=00, illegal=0.
5. Exhaustive sweep:
   - All 1024 opcode/funct3 combinations; check each output with case-inequality against the table.
   - Unlisted opcodes (e.g. 0000000, 1111111, 0001111) -> all outputs zero and illegal=1.
6. Sticky flag:
   - Hold rst_n=0 -> illegal_seen=0.
   - Release rst_n, apply opcode 0000000 across a rising clk edge -> illegal_seen=1.
   - Apply a legal opcode for several cycles -> illegal_seen stays 1.
   - Drop rst_n mid-cycle -> illegal_seen=0 immediately, without waiting for a clk edge.
